// File: rtl/uart_fifo_core.sv
// UART core: TX path with a small FIFO feeding a serial framer, plus an independent
// RX path with a 2-flop synchronizer, mid-bit sampling, parity and framing checks.
module uart_fifo_core #(
    parameter int DATA_W      = 8,
    parameter int CLK_PER_BIT = 16,
    parameter int PARITY_EN   = 1,
    parameter int PARITY_ODD  = 0,
    parameter int STOP_BITS   = 1,
    parameter int TX_DEPTH    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] din,
    input  logic              wr_en,
    output logic              tx_full,
    output logic              tx_busy,
    output logic              tx,
    input  logic              rx,
    output logic              ready,
    output logic [DATA_W-1:0] dout,
    output logic              parity_err,
    output logic              frame_err,
    output logic [2:0]        dbg_tx_state_o,
    output logic [2:0]        dbg_rx_state_o
);
    localparam int AW = $clog2(TX_DEPTH);
    localparam int CW = $clog2(CLK_PER_BIT);
    localparam int BW = $clog2(DATA_W);
    localparam logic [AW:0]   DEPTH_C   = TX_DEPTH[AW:0];
    localparam logic [CW-1:0] CNT_MAX   = CW'(CLK_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF  = CW'(CLK_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] BIT_MAX   = BW'(DATA_W - 1);
    localparam logic          STOP_LAST = (STOP_BITS == 2);
    localparam logic          PAR       = (PARITY_EN != 0);
    localparam logic          ODD       = (PARITY_ODD != 0);

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;

    tx_state_e         tx_state_q;
    logic [CW-1:0]     tx_cnt_q;
    logic [BW-1:0]     tx_bit_q;
    logic              tx_stop_q;
    logic [DATA_W-1:0] tx_sh_q;
    logic              tx_par_q;
    logic              tx_q;

    logic [DATA_W-1:0] mem_q [TX_DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       count_q, count_d;
    logic              push, pop;

    // The framer pops from IDLE or on the last cycle of its final stop bit, so
    // back-to-back words leave no idle gap on the line.
    assign pop = (count_q != '0) &&
                 ((tx_state_q == TX_IDLE) ||
                  (tx_state_q == TX_STOP && tx_cnt_q == CNT_MAX && tx_stop_q == STOP_LAST));
    assign tx_full = (count_q == DEPTH_C);
    assign push    = wr_en && (!tx_full || pop);
    assign tx_busy = (count_q != '0) || (tx_state_q != TX_IDLE);
    assign tx      = tx_q;
    assign dbg_tx_state_o = tx_state_q;

    always_comb begin
        count_d = count_q;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= din;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_stop_q  <= 1'b0;
            tx_sh_q    <= '0;
            tx_par_q   <= 1'b0;
            tx_q       <= 1'b1;
        end else if (pop) begin
            tx_state_q <= TX_START;
            tx_cnt_q   <= '0;
            tx_sh_q    <= mem_q[rd_ptr_q];
            tx_par_q   <= (^mem_q[rd_ptr_q]) ^ ODD;
            tx_q       <= 1'b0;
        end else if (tx_state_q == TX_IDLE) begin
            tx_q <= 1'b1;
        end else if (tx_cnt_q != CNT_MAX) begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
        end else begin
            tx_cnt_q <= '0;
            case (tx_state_q)
                TX_START: begin
                    tx_state_q <= TX_DATA;
                    tx_bit_q   <= '0;
                    tx_q       <= tx_sh_q[0];
                end
                TX_DATA: begin
                    if (tx_bit_q == BIT_MAX) begin
                        tx_stop_q  <= 1'b0;
                        tx_state_q <= PAR ? TX_PARITY : TX_STOP;
                        tx_q       <= PAR ? tx_par_q : 1'b1;
                    end else begin
                        tx_bit_q <= tx_bit_q + 1'b1;
                        tx_sh_q  <= tx_sh_q >> 1;
                        tx_q     <= tx_sh_q[1];
                    end
                end
                TX_PARITY: begin
                    tx_state_q <= TX_STOP;
                    tx_stop_q  <= 1'b0;
                    tx_q       <= 1'b1;
                end
                TX_STOP: begin
                    tx_q <= 1'b1;
                    if (tx_stop_q == STOP_LAST) tx_state_q <= TX_IDLE;
                    else                        tx_stop_q  <= 1'b1;
                end
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

    logic              sync1_q, sync2_q;
    rx_state_e         rx_state_q;
    logic [CW-1:0]     rx_cnt_q;
    logic [BW-1:0]     rx_bit_q;
    logic [DATA_W-1:0] rx_sh_q;
    logic              rx_par_q;
    logic              rx_armed_q;
    logic              ready_q, perr_q, ferr_q;
    logic [DATA_W-1:0] dout_q;

    assign ready      = ready_q;
    assign dout       = dout_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign dbg_rx_state_o = rx_state_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
        end
    end

    // rx_armed_q drops after a low stop bit so a held-low line cannot fake a start bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
            rx_par_q   <= 1'b0;
            rx_armed_q <= 1'b1;
            ready_q    <= 1'b0;
            dout_q     <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            case (rx_state_q)
                RX_IDLE: begin
                    rx_cnt_q <= '0;
                    if (sync2_q)         rx_armed_q <= 1'b1;
                    else if (rx_armed_q) rx_state_q <= RX_START;
                end
                RX_START: begin
                    if (rx_cnt_q == CNT_HALF) begin
                        rx_cnt_q   <= '0;
                        rx_bit_q   <= '0;
                        rx_state_q <= sync2_q ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                default: begin
                    if (rx_cnt_q != CNT_MAX) begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end else begin
                        rx_cnt_q <= '0;
                        if (rx_state_q == RX_DATA) begin
                            rx_sh_q <= {sync2_q, rx_sh_q[DATA_W-1:1]};
                            if (rx_bit_q == BIT_MAX) rx_state_q <= PAR ? RX_PARITY : RX_STOP;
                            else                     rx_bit_q   <= rx_bit_q + 1'b1;
                        end else if (rx_state_q == RX_PARITY) begin
                            rx_par_q   <= sync2_q;
                            rx_state_q <= RX_STOP;
                        end else begin
                            dout_q     <= rx_sh_q;
                            perr_q     <= PAR & (rx_par_q ^ (^rx_sh_q) ^ ODD);
                            ferr_q     <= !sync2_q;
                            ready_q    <= 1'b1;
                            rx_armed_q <= sync2_q;
                            rx_state_q <= RX_IDLE;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_fifo_core.sv
// Self-checking bench for uart_fifo_core: directed frames plus randomized TX/RX traffic
// compared against a frame-level reference model and expected queues.
module tb_uart_fifo_core;
    localparam int DATA_W     = 8;
    localparam int CPB        = 16;
    localparam int PARITY_EN  = 1;
    localparam int PARITY_ODD = 0;
    localparam int STOP_BITS  = 1;
    localparam int TX_DEPTH   = 4;
    localparam int FRAME_BITS = 1 + DATA_W + PARITY_EN + STOP_BITS;
    localparam int FRAME_CYC  = FRAME_BITS * CPB;
    localparam int EW         = DATA_W + 2;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [DATA_W-1:0] din = '0;
    logic              wr_en = 1'b0;
    logic              tx_full, tx_busy, tx, ready, parity_err, frame_err;
    logic [DATA_W-1:0] dout;
    logic [2:0]        dbg_tx, dbg_rx;
    logic              loop_en = 1'b0;
    logic              rx_drv = 1'b1;
    logic              rx_w;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int rst_cnt = 0;
    int n_ready = 0;
    int tx_frames = 0;
    logic [DATA_W-1:0] tx_exp_q[$];
    logic [EW-1:0]     rx_exp_q[$];
    int                tx_start_q[$];

    assign rx_w = loop_en ? tx : rx_drv;

    uart_fifo_core #(
        .DATA_W(DATA_W), .CLK_PER_BIT(CPB), .PARITY_EN(PARITY_EN),
        .PARITY_ODD(PARITY_ODD), .STOP_BITS(STOP_BITS), .TX_DEPTH(TX_DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .din(din), .wr_en(wr_en),
        .tx_full(tx_full), .tx_busy(tx_busy), .tx(tx), .rx(rx_w),
        .ready(ready), .dout(dout), .parity_err(parity_err), .frame_err(frame_err),
        .dbg_tx_state_o(dbg_tx), .dbg_rx_state_o(dbg_rx)
    );

    // clock / reset bookkeeping
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge reset) rst_cnt <= rst_cnt + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // reference model: expected parity bit and the k-th line bit of a frame
    function automatic logic par_bit(input logic [DATA_W-1:0] d);
        return (^d) ^ (PARITY_ODD != 0);
    endfunction

    function automatic logic frame_bit(input logic [DATA_W-1:0] d, input int k);
        if (k == 0) return 1'b0;
        if (k <= DATA_W) return d[k-1];
        if (k == DATA_W + 1) return par_bit(d);
        return 1'b1;
    endfunction

    // RX scoreboard
    always @(negedge clk) begin : rx_sb
        logic [EW-1:0] e;
        if (reset === 1'b1 && ready === 1'b1) begin
            n_ready <= n_ready + 1;
            check_eq("rx_expected_pending", rx_exp_q.size() > 0, 1);
            if (rx_exp_q.size() > 0) begin
                e = rx_exp_q.pop_front();
                check_eq("rx_word", {frame_err, parity_err, dout}, e);
            end
        end
    end

    // TX line decoder
    initial begin : tx_mon
        logic prev;
        logic [DATA_W-1:0] d;
        logic p, s;
        int sc, r0;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && prev === 1'b1 && tx === 1'b0) begin
                sc = cyc;
                r0 = rst_cnt;
                repeat (CPB / 2) @(negedge clk);
                for (int i = 0; i < DATA_W; i++) begin
                    repeat (CPB) @(negedge clk);
                    d[i] = tx;
                end
                repeat (CPB) @(negedge clk);
                p = tx;
                repeat (CPB) @(negedge clk);
                s = tx;
                if (rst_cnt == r0) begin
                    tx_frames++;
                    tx_start_q.push_back(sc);
                    check_eq("tx_expected_pending", tx_exp_q.size() > 0, 1);
                    if (tx_exp_q.size() > 0) check_eq("tx_word", d, tx_exp_q.pop_front());
                    check_eq("tx_parity", p, par_bit(d));
                    check_eq("tx_stop", s, 1);
                end
            end
            prev = tx;
        end
    end

    // driver tasks
    task automatic send_rx(input logic [DATA_W-1:0] d, input logic p, input logic s,
                           input int tail_low);
        rx_exp_q.push_back({~s, p != par_bit(d), d});
        rx_drv = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < DATA_W; i++) begin
            rx_drv = d[i];
            repeat (CPB) @(posedge clk);
        end
        rx_drv = p;
        repeat (CPB) @(posedge clk);
        rx_drv = s;
        repeat (CPB) @(posedge clk);
        if (tail_low > 0) begin
            rx_drv = 1'b0;
            repeat (tail_low) @(posedge clk);
        end
        rx_drv = 1'b1;
        repeat (2 * CPB) @(posedge clk);
    endtask

    task automatic wait_tx_idle(input int limit, input string tag);
        int n;
        n = 0;
        while (tx_busy === 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, tx_busy, 0);
    endtask

    task automatic tx_writer(input int n_words);
        logic [DATA_W-1:0] w;
        int guard;
        for (int i = 0; i < n_words; i++) begin
            repeat ($urandom_range(1, 30)) @(negedge clk);
            guard = 0;
            while (tx_full === 1'b1 && guard < 2 * FRAME_CYC) begin
                @(negedge clk);
                guard++;
            end
            check_eq("tx_room_wait", tx_full, 0);
            w = DATA_W'($urandom_range(0, (1 << DATA_W) - 1));
            din = w;
            wr_en = 1'b1;
            tx_exp_q.push_back(w);
            @(negedge clk);
            wr_en = 1'b0;
        end
    endtask

    task automatic rx_random(input int n_frames);
        logic [DATA_W-1:0] d;
        logic p, s;
        for (int i = 0; i < n_frames; i++) begin
            d = DATA_W'($urandom_range(0, (1 << DATA_W) - 1));
            p = ($urandom_range(0, 3) == 0) ? ~par_bit(d) : par_bit(d);
            s = ($urandom_range(0, 3) != 0);
            send_rx(d, p, s, 0);
        end
    endtask

    initial begin : main
        logic [DATA_W-1:0] a5;
        logic [DATA_W-1:0] w;
        int r0, f0;

        repeat (3) @(negedge clk);
        check_eq("rst_tx", tx, 1);
        check_eq("rst_busy", tx_busy, 0);
        check_eq("rst_full", tx_full, 0);
        check_eq("rst_ready", ready, 0);
        check_eq("rst_dout", dout, 0);
        check_eq("rst_perr", parity_err, 0);
        check_eq("rst_ferr", frame_err, 0);
        check_eq("rst_tx_state", dbg_tx, 0);
        check_eq("rst_rx_state", dbg_rx, 0);
        reset = 1'b1;
        repeat (4) @(negedge clk);

        // single 0xA5 frame, looped back
        loop_en = 1'b1;
        a5 = 8'hA5;
        din = a5;
        wr_en = 1'b1;
        tx_exp_q.push_back(a5);
        rx_exp_q.push_back({2'b00, a5});
        @(posedge clk);
        #1 wr_en = 1'b0;
        check_eq("tx_before_start", tx, 1);
        check_eq("busy_after_write", tx_busy, 1);
        @(posedge clk);
        #1 check_eq("start_latency", tx, 0);
        for (int k = 0; k < FRAME_BITS; k++) begin
            repeat (CPB / 2) @(posedge clk);
            #1 check_eq($sformatf("a5_bit%0d", k), tx, frame_bit(a5, k));
            repeat (CPB / 2) @(posedge clk);
        end
        #1 check_eq("idle_after_frame", tx_busy, 0);
        check_eq("tx_high_after_frame", tx, 1);
        repeat (20) @(negedge clk);

        // wr_en held for TX_DEPTH+2 cycles into an idle core
        tx_start_q.delete();
        wr_en = 1'b1;
        for (int i = 0; i < TX_DEPTH + 2; i++) begin
            w = DATA_W'($urandom_range(0, (1 << DATA_W) - 1));
            din = w;
            if (i <= TX_DEPTH) begin
                tx_exp_q.push_back(w);
                rx_exp_q.push_back({2'b00, w});
            end
            @(posedge clk);
            #1 check_eq($sformatf("burst_full%0d", i), tx_full, (i >= TX_DEPTH));
        end
        wr_en = 1'b0;
        wait_tx_idle((TX_DEPTH + 2) * FRAME_CYC, "burst_drain");
        repeat (CPB) @(negedge clk);
        check_eq("burst_frames", tx_start_q.size(), TX_DEPTH + 1);
        if (tx_start_q.size() == TX_DEPTH + 1) begin
            for (int i = 1; i <= TX_DEPTH; i++)
                check_eq($sformatf("burst_gap%0d", i), tx_start_q[i] - tx_start_q[i-1], FRAME_CYC);
        end
        loop_en = 1'b0;
        repeat (CPB) @(negedge clk);

        // parity error frame, then framing error with the line held low
        send_rx(8'h3C, ~par_bit(8'h3C), 1'b1, 0);
        r0 = n_ready;
        send_rx(8'h55, par_bit(8'h55), 1'b0, 3 * CPB);
        check_eq("ferr_single_ready", n_ready - r0, 1);
        w = DATA_W'($urandom_range(0, (1 << DATA_W) - 1));
        send_rx(w, par_bit(w), 1'b1, 0);
        check_eq("after_ferr_ready", n_ready - r0, 2);

        // short low glitch
        r0 = n_ready;
        @(negedge clk);
        rx_drv = 1'b0;
        repeat (4) @(posedge clk);
        rx_drv = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        check_eq("glitch_no_ready", n_ready - r0, 0);
        check_eq("glitch_rx_idle", dbg_rx, 0);

        // independent random TX and RX traffic
        fork
            tx_writer(6);
            rx_random(8);
        join
        wait_tx_idle(8 * FRAME_CYC, "random_drain");
        repeat (2 * CPB) @(negedge clk);

        // reset during the data bits with two words queued
        for (int i = 0; i < 3; i++) begin
            w = DATA_W'($urandom_range(0, (1 << DATA_W) - 1));
            din = w;
            wr_en = 1'b1;
            tx_exp_q.push_back(w);
            @(negedge clk);
        end
        wr_en = 1'b0;
        repeat (40) @(negedge clk);
        check_eq("busy_before_reset", tx_busy, 1);
        #2 reset = 1'b0;
        #1;
        check_eq("abort_tx", tx, 1);
        check_eq("abort_busy", tx_busy, 0);
        check_eq("abort_full", tx_full, 0);
        tx_exp_q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        f0 = tx_frames;
        repeat (3 * FRAME_CYC) @(negedge clk);
        check_eq("no_frames_after_reset", tx_frames - f0, 0);
        check_eq("idle_after_reset", tx_busy, 0);
        check_eq("tx_high_after_reset", tx, 1);

        check_eq("tx_exp_drained", tx_exp_q.size(), 0);
        check_eq("rx_exp_drained", rx_exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
